// File: rtl/spynet_out_unpacker.sv
// Purpose : buffers a burst of packed 2*BITS words and serializes each one
//           as element A (low half) then element B (high half).
// Latency : a word pushed into an empty FIFO with an idle serializer shows
//           element A one edge later. Throughput is one element per cycle.
// Backpr. : m_ready low holds m_data/m_valid. Words arriving while the FIFO
//           is full are dropped and flagged in the sticky overflow bit.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           arms a burst of word_count packed words (IDLE only)
//   word_count      number of packed words expected in the burst
//   in_valid        outputdata carries a word (sampled in CAPTURE only)
//   outputdata      packed word, [BITS-1:0]=A, [2*BITS-1:BITS]=B
//   m_valid/m_ready element handshake toward the consumer
//   m_data          unpacked element
//   m_last          element B of the final buffered word of the burst
//   busy            state is not IDLE
//   done            one-cycle pulse at the end of a burst
//   overflow        sticky, a word was dropped on a full FIFO
module spynet_out_unpacker #(
  parameter int BITS       = 16,
  parameter int DEPTH      = 16,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [COUNT_BITS-1:0] word_count,
  input  logic                  in_valid,
  input  logic [2*BITS-1:0]     outputdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS-1:0]       m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [COUNT_BITS-1:0] remaining_q, remaining_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  ser_vld_q, ser_vld_d;
  logic                  ser_sel_q, ser_sel_d;   // 0: element A shown, 1: element B shown
  logic [2*BITS-1:0]     ser_word_q, ser_word_d;

  // Packed-word storage; contents are don't-care while unoccupied, so no reset.
  logic [2*BITS-1:0]     mem_q [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic xfer;
  logic ser_free;
  logic last_xfer;

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (count_q == '0);
    // Full is judged on the registered occupancy, so a same-cycle pop does
    // not rescue a word that arrives while the FIFO is full.
    fifo_full  = (count_q == FULL_CNT);
    push       = (state_q == CAPTURE) && in_valid && !fifo_full;
    xfer       = ser_vld_q && m_ready;
    // The serializer can take a new word when empty, or when element B is
    // leaving this cycle, which keeps the stream at one element per cycle.
    ser_free   = !ser_vld_q || (ser_sel_q && xfer);
    pop        = ser_free && !fifo_empty && (state_q != IDLE);
    // Once in DRAIN every word has been offered, so B of the serialized word
    // with an empty FIFO behind it is the end of the burst.
    m_last     = ser_vld_q && ser_sel_q && (state_q == DRAIN) && fifo_empty;
    last_xfer  = xfer && m_last;
  end

  // ---------------------------------------------------------------------------
  // Burst state machine: next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            remaining_d = word_count;
            ovf_d       = 1'b0;
            state_d     = CAPTURE;
          end else begin
            // Empty burst: report completion without touching the datapath.
            done_d = 1'b1;
          end
        end
      end

      CAPTURE: begin
        if (in_valid) begin
          remaining_d = remaining_q - 1'b1;
          if (fifo_full) begin
            ovf_d = 1'b1;
          end
          if (remaining_q == COUNT_BITS'(1)) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Second term covers a burst whose words were all dropped or already
        // gone, leaving nothing to emit.
        if (last_xfer || (fifo_empty && !ser_vld_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and serializer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ser_vld_d  = ser_vld_q;
    ser_sel_d  = ser_sel_q;
    ser_word_d = ser_word_q;

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (xfer && !ser_sel_q) begin
      ser_sel_d = 1'b1;
    end

    if (pop) begin
      ser_vld_d  = 1'b1;
      ser_sel_d  = 1'b0;
      ser_word_d = mem_q[rd_ptr_q];
    end else if (xfer && ser_sel_q) begin
      ser_vld_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      ser_vld_q   <= 1'b0;
      ser_sel_q   <= 1'b0;
      ser_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      ser_vld_q   <= ser_vld_d;
      ser_sel_q   <= ser_sel_d;
      ser_word_q  <= ser_word_d;
    end
  end

  // Push never targets the slot being popped: that would need count_q == DEPTH,
  // where push is blocked.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= outputdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m_valid  = ser_vld_q;
    m_data   = ser_sel_q ? ser_word_q[2*BITS-1:BITS] : ser_word_q[BITS-1:0];
    busy     = (state_q != IDLE);
    done     = done_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_spynet_out_unpacker.sv
module tb_spynet_out_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] word_count;
  logic        in_valid;
  logic [31:0] outputdata;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  spynet_out_unpacker #(
    .BITS       (16),
    .DEPTH      (16),
    .COUNT_BITS (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .outputdata (outputdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  typedef struct {
    logic        start;
    logic [15:0] wc;
    logic        iv;
    logic [31:0] dat;
    logic        rdy;
    logic        e_vld;
    logic [15:0] e_dat;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs [20];

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int last_seen = 0;
  int elem_seen = 0;

  logic [15:0] exp_dat [$];
  logic        exp_last [$];

  function automatic vec_t mk(input logic s, input logic [15:0] wc, input logic iv,
                              input logic [31:0] d, input logic r, input logic ev,
                              input logic [15:0] ed, input logic el, input logic eb,
                              input logic edn);
    vec_t v;
    v.start = s;  v.wc = wc;  v.iv = iv;  v.dat = d;  v.rdy = r;
    v.e_vld = ev; v.e_dat = ed; v.e_last = el; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic is_last);
    exp_dat.push_back(w[15:0]);
    exp_last.push_back(1'b0);
    exp_dat.push_back(w[31:16]);
    exp_last.push_back(is_last);
  endtask

  // One clock cycle; at the falling edge the element stream is scoreboarded.
  task automatic tick();
    logic [15:0] ed;
    logic        el;
    @(negedge clk);
    if (done) done_seen++;
    if (m_valid && m_ready) begin
      elem_seen++;
      if (m_last) last_seen++;
      if (exp_dat.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_elem: got %0h, expected no element", m_data);
      end else begin
        ed = exp_dat.pop_front();
        el = exp_last.pop_front();
        chk("elem_data", {16'h0, m_data}, {16'h0, ed});
        chk("elem_last", {31'h0, m_last}, {31'h0, el});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] wc);
    start = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
    word_count = '0;
  endtask

  task automatic feed_word(input logic [31:0] w);
    in_valid = 1'b1;
    outputdata = w;
    tick();
    in_valid = 1'b0;
    outputdata = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, expected 0", name, n);
    end
    tick();  // the done pulse cycle is counted here
    chk({name, "_done_low"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int d0;
    int l0;
    int e0;
    logic [31:0] w;

    rst_n = 1'b0;
    start = 1'b0;
    word_count = '0;
    in_valid = 1'b0;
    outputdata = '0;
    m_ready = 1'b0;

    // Basic burst (5,4,7,6) then backpressured single word (9 held, then 10).
    vecs[0]  = mk(1, 16'd2, 0, 32'h0,         0, 0, 16'h0, 0, 0, 0);
    vecs[1]  = mk(0, 16'd0, 1, 32'h0004_0005, 0, 0, 16'h0, 0, 1, 0);
    vecs[2]  = mk(0, 16'd0, 1, 32'h0006_0007, 1, 0, 16'h0, 0, 1, 0);
    vecs[3]  = mk(0, 16'd0, 0, 32'h0,         1, 1, 16'h5, 0, 1, 0);
    vecs[4]  = mk(0, 16'd0, 0, 32'h0,         1, 1, 16'h4, 0, 1, 0);
    vecs[5]  = mk(0, 16'd0, 0, 32'h0,         1, 1, 16'h7, 0, 1, 0);
    vecs[6]  = mk(0, 16'd0, 0, 32'h0,         1, 1, 16'h6, 1, 1, 0);
    vecs[7]  = mk(0, 16'd0, 0, 32'h0,         1, 0, 16'h0, 0, 0, 1);
    vecs[8]  = mk(1, 16'd1, 0, 32'h0,         0, 0, 16'h0, 0, 0, 0);
    vecs[9]  = mk(0, 16'd0, 1, 32'h000A_0009, 0, 0, 16'h0, 0, 1, 0);
    vecs[10] = mk(0, 16'd0, 0, 32'h0,         0, 0, 16'h0, 0, 1, 0);
    vecs[11] = mk(0, 16'd0, 0, 32'h0,         0, 1, 16'h9, 0, 1, 0);
    vecs[12] = mk(0, 16'd0, 0, 32'h0,         0, 1, 16'h9, 0, 1, 0);
    vecs[13] = mk(0, 16'd0, 0, 32'h0,         0, 1, 16'h9, 0, 1, 0);
    vecs[14] = mk(0, 16'd0, 0, 32'h0,         0, 1, 16'h9, 0, 1, 0);
    vecs[15] = mk(0, 16'd0, 0, 32'h0,         0, 1, 16'h9, 0, 1, 0);
    vecs[16] = mk(0, 16'd0, 0, 32'h0,         1, 1, 16'h9, 0, 1, 0);
    vecs[17] = mk(0, 16'd0, 0, 32'h0,         1, 1, 16'hA, 1, 1, 0);
    vecs[18] = mk(0, 16'd0, 0, 32'h0,         1, 0, 16'h0, 0, 0, 1);
    vecs[19] = mk(0, 16'd0, 0, 32'h0,         0, 0, 16'h0, 0, 0, 0);

    // Reset values
    #2;
    chk("rst_vld",  {31'h0, m_valid},  32'h0);
    chk("rst_data", {16'h0, m_data},   32'h0);
    chk("rst_last", {31'h0, m_last},   32'h0);
    chk("rst_busy", {31'h0, busy},     32'h0);
    chk("rst_done", {31'h0, done},     32'h0);
    chk("rst_ovf",  {31'h0, overflow}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 20; i++) begin
      start = vecs[i].start;
      word_count = vecs[i].wc;
      in_valid = vecs[i].iv;
      outputdata = vecs[i].dat;
      m_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_vld", i), {31'h0, m_valid}, {31'h0, vecs[i].e_vld});
      if (vecs[i].e_vld)
        chk($sformatf("vec%0d_data", i), {16'h0, m_data}, {16'h0, vecs[i].e_dat});
      chk($sformatf("vec%0d_last", i), {31'h0, m_last}, {31'h0, vecs[i].e_last});
      chk($sformatf("vec%0d_busy", i), {31'h0, busy},   {31'h0, vecs[i].e_busy});
      chk($sformatf("vec%0d_done", i), {31'h0, done},   {31'h0, vecs[i].e_done});
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    word_count = '0;
    in_valid = 1'b0;
    outputdata = '0;
    m_ready = 1'b0;

    // Zero word count
    d0 = done_seen;
    e0 = elem_seen;
    do_start(16'd0);
    chk("zc_done", {31'h0, done},    32'h1);
    chk("zc_busy", {31'h0, busy},    32'h0);
    chk("zc_vld",  {31'h0, m_valid}, 32'h0);
    tick();
    chk("zc_done_low", {31'h0, done}, 32'h0);
    chk("zc_done_cnt", done_seen - d0, 32'd1);
    chk("zc_elems",    elem_seen - e0, 32'd0);

    // Overflow: 20 words, consumer stalled, words 18-20 dropped
    d0 = done_seen;
    l0 = last_seen;
    e0 = elem_seen;
    m_ready = 1'b0;
    do_start(16'd20);
    for (int k = 1; k <= 20; k++) begin
      w = {16'h0100 + 16'(k), 16'h0200 + 16'(k)};
      if (k <= 17) push_exp(w, k == 17);
      feed_word(w);
    end
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    chk("ovf_vld",  {31'h0, m_valid},  32'h1);
    chk("ovf_head", {16'h0, m_data},   32'h0201);
    chk("ovf_busy", {31'h0, busy},     32'h1);
    chk("ovf_last", {31'h0, m_last},   32'h0);
    m_ready = 1'b1;
    wait_idle("ovf");
    chk("ovf_elems",  elem_seen - e0, 32'd34);
    chk("ovf_left",   exp_dat.size(), 32'd0);
    chk("ovf_lasts",  last_seen - l0, 32'd1);
    chk("ovf_dones",  done_seen - d0, 32'd1);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    do_start(16'd1);
    chk("ovf_clear", {31'h0, overflow}, 32'h0);
    push_exp(32'hBEEF_CAFE, 1'b1);
    feed_word(32'hBEEF_CAFE);
    wait_idle("after_ovf");
    chk("after_ovf_left", exp_dat.size(), 32'd0);

    // Mid-burst reset
    m_ready = 1'b0;
    do_start(16'd8);
    for (int k = 0; k < 4; k++) feed_word(32'h1111_0000 + 32'(k));
    tick();
    chk("mr_pre_vld", {31'h0, m_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_vld",  {31'h0, m_valid},  32'h0);
    chk("mr_data", {16'h0, m_data},   32'h0);
    chk("mr_last", {31'h0, m_last},   32'h0);
    chk("mr_busy", {31'h0, busy},     32'h0);
    chk("mr_done", {31'h0, done},     32'h0);
    chk("mr_ovf",  {31'h0, overflow}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    d0 = done_seen;
    e0 = elem_seen;
    l0 = last_seen;
    for (int k = 0; k < 6; k++) begin
      chk("mr_post_vld",  {31'h0, m_valid}, 32'h0);
      chk("mr_post_busy", {31'h0, busy},    32'h0);
      tick();
    end
    chk("mr_post_dones", done_seen - d0, 32'd0);
    chk("mr_post_elems", elem_seen - e0, 32'd0);
    push_exp(32'h0002_0001, 1'b1);
    do_start(16'd1);
    feed_word(32'h0002_0001);
    wait_idle("mr_new");
    chk("mr_new_elems", elem_seen - e0, 32'd2);
    chk("mr_new_lasts", last_seen - l0, 32'd1);
    chk("mr_new_dones", done_seen - d0, 32'd1);

    // Two back-to-back 12-word bursts, pointers wrap in the second
    m_ready = 1'b1;
    d0 = done_seen;
    e0 = elem_seen;
    l0 = last_seen;
    for (int b = 0; b < 2; b++) begin
      do_start(16'd12);
      for (int k = 0; k < 12; k++) begin
        w = {16'h3000 + 16'(b * 16 + k), 16'h4000 + 16'(b * 16 + k)};
        push_exp(w, k == 11);
        feed_word(w);
      end
      wait_idle("wrap");
    end
    chk("wrap_elems", elem_seen - e0, 32'd48);
    chk("wrap_lasts", last_seen - l0, 32'd2);
    chk("wrap_dones", done_seen - d0, 32'd2);
    chk("wrap_left",  exp_dat.size(), 32'd0);
    chk("wrap_busy",  {31'h0, busy},  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
